// File: rtl/sdram_byte_requester_if.sv
//------------------------------------------------------------------------------
// sdram_byte_requester_if
// Client byte request / read response bundle between the VDP arbiter and the
// SDRAM byte requester.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sdram_byte_requester_if #(
    parameter int ADDR_WIDTH = 23
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [7:0]            req_wdata;
    logic                  rsp_valid;
    logic [7:0]            rsp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

`default_nettype wire

// File: rtl/sdram_byte_requester.sv
//------------------------------------------------------------------------------
// sdram_byte_requester
// Byte-request front end for the SDRAM controller with auto-refresh scheduling.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sdram_byte_requester #(
    parameter int REFRESH_INTERVAL = 1500,
    parameter int ADDR_WIDTH       = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    sdram_byte_requester_if.slave req,
    output logic                  refresh_miss,
    output logic                  sdram_rd,
    output logic                  sdram_wr,
    output logic                  sdram_refresh,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [31:0]           sdram_din32,
    output logic [3:0]            sdram_wdm,
    input  logic [31:0]           sdram_dout32,
    input  logic                  sdram_data_ready,
    input  logic                  sdram_busy,
    input  logic                  sdram_enabled
);
    localparam int CNT_W = $clog2(REFRESH_INTERVAL);

    typedef enum logic [2:0] {
        WAIT_EN   = 3'd0,
        IDLE      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  ready;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [7:0]            wdata_q;
    logic [1:0]            lane_q;
    logic [3:0]            wdm_q;
    logic                  rd_pending;
    logic                  rsp_valid_q;
    logic [7:0]            rsp_rdata_q;
    logic [CNT_W-1:0]      refresh_cnt;
    logic                  refresh_pending;
    logic                  refresh_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_EN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        ready         = 1'b0;
        sdram_rd      = 1'b0;
        sdram_wr      = 1'b0;
        sdram_refresh = 1'b0;
        case (state)
            WAIT_EN: begin
                if (sdram_enabled && !sdram_busy) state_next = IDLE;
            end
            IDLE: begin
                // A pending refresh blocks new client requests until it is issued.
                if (refresh_pending) begin
                    if (!sdram_busy) begin
                        sdram_refresh = 1'b1;
                        state_next    = WAIT_BUSY;
                    end
                end else begin
                    ready = !sdram_busy;
                    if (!sdram_busy && req.req_valid) state_next = ISSUE;
                end
            end
            ISSUE: begin
                sdram_rd   = !wr_q;
                sdram_wr   = wr_q;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (sdram_busy) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!sdram_busy) state_next = IDLE;
            end
            default: state_next = WAIT_EN;
        endcase
    end

    assign accept = ready && req.req_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= 8'h00;
            lane_q      <= 2'b00;
            wdm_q       <= 4'b1111;
            rd_pending  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                addr_q     <= req.req_addr;
                wr_q       <= req.req_wr;
                wdata_q    <= req.req_wdata;
                lane_q     <= req.req_addr[1:0];
                wdm_q      <= req.req_wr ? ~(4'b0001 << req.req_addr[1:0]) : 4'b0000;
                rd_pending <= !req.req_wr;
            end
            // Only the first data_ready of a read is taken; later ones are ignored.
            if (rd_pending && sdram_data_ready &&
                (state == WAIT_BUSY || state == WAIT_DONE)) begin
                rsp_rdata_q <= sdram_dout32[{lane_q, 3'b000} +: 8];
                rsp_valid_q <= 1'b1;
                rd_pending  <= 1'b0;
            end
            if (state == WAIT_DONE && !sdram_busy) begin
                wdm_q      <= 4'b1111;
                rd_pending <= 1'b0;
            end
        end
    end

    assign refresh_wrap = (refresh_cnt == CNT_W'(REFRESH_INTERVAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt     <= '0;
            refresh_pending <= 1'b0;
            refresh_miss    <= 1'b0;
        end else begin
            refresh_miss <= 1'b0;
            if (state == WAIT_EN) begin
                refresh_cnt <= '0;
            end else if (refresh_wrap) begin
                // A refresh issued on the wrap cycle is not a miss; the new one queues.
                refresh_cnt     <= '0;
                refresh_pending <= 1'b1;
                refresh_miss    <= refresh_pending && !sdram_refresh;
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
                if (sdram_refresh) refresh_pending <= 1'b0;
            end
        end
    end

    assign req.req_ready = ready;
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_rdata = rsp_rdata_q;
    assign sdram_addr    = addr_q;
    assign sdram_din32   = {4{wdata_q}};
    assign sdram_wdm     = wdm_q;

endmodule

`default_nettype wire
